// File: rtl/axi_wr_slave_bram.sv
// AXI3 write-only slave (AW/W/B) backed by a 64-bit BRAM, with a registered side read port.
// Accepts INCR bursts of 1-16 beats and returns one B response per burst.
module axi_wr_slave_bram #(
    parameter logic [31:0] BASE_ADDR   = 32'h4300_0000,
    parameter int          DEPTH_WORDS = 1024,
    localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             aclk,
    input  logic             rst_i,
    input  logic [31:0]      s_axi_awaddr,
    input  logic             s_axi_awvalid,
    output logic             s_axi_awready,
    input  logic [3:0]       s_axi_awlen,
    input  logic [2:0]       s_axi_awsize,
    input  logic [1:0]       s_axi_awburst,
    input  logic [63:0]      s_axi_wdata,
    input  logic [7:0]       s_axi_wstrb,
    input  logic             s_axi_wlast,
    input  logic             s_axi_wvalid,
    output logic             s_axi_wready,
    output logic [1:0]       s_axi_bresp,
    output logic             s_axi_bvalid,
    input  logic             s_axi_bready,
    input  logic [IDX_W-1:0] rd_addr_i,
    output logic [63:0]      rd_data_o,
    output logic [15:0]      burst_count_o,
    output logic             err_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) << 3;

    // Range check first (33-bit so the end address cannot wrap), then format check.
    function automatic logic [1:0] aw_check(input logic [31:0] addr,
                                            input logic [3:0]  len,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
        logic [32:0] off;
        logic [32:0] span;
        logic [32:0] end_b;
        off   = {1'b0, addr} - {1'b0, BASE_ADDR};
        span  = {28'd0, ({1'b0, len} + 5'd1)} << 3;
        end_b = off + span;
        if ((addr < BASE_ADDR) || (end_b > LIMIT_BYTES)) begin
            return RESP_DECERR;
        end else if ((size != 3'd3) || (burst != 2'b01) || (addr[2:0] != 3'd0)) begin
            return RESP_SLVERR;
        end else begin
            return RESP_OKAY;
        end
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        len_r;
    logic [3:0]        len_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_s;
    logic [4:0]        beat_r;
    logic [4:0]        beat_s;
    logic [1:0]        resp_r;
    logic [1:0]        resp_s;
    logic [15:0]       count_s;
    logic              err_s;
    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_idx_s;
    logic [32:0]       aw_off_s;
    logic              is_last_s;
    logic [63:0]       mem_r [DEPTH_WORDS];

    // Next-state and next-value decode for the burst FSM.
    always_comb begin
        state_s   = state_r;
        len_s     = len_r;
        idx_s     = idx_r;
        beat_s    = beat_r;
        resp_s    = resp_r;
        count_s   = burst_count_o;
        err_s     = err_o;
        mem_we_s  = 1'b0;
        aw_off_s  = {1'b0, s_axi_awaddr} - {1'b0, BASE_ADDR};
        mem_idx_s = idx_r + IDX_W'(beat_r);
        is_last_s = (beat_r == {1'b0, len_r});
        case (state_r)
            ST_INIT: begin
                state_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (s_axi_awvalid) begin
                    len_s   = s_axi_awlen;
                    idx_s   = IDX_W'(aw_off_s >> 3);
                    resp_s  = aw_check(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
                    beat_s  = 5'd0;
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (s_axi_wvalid) begin
                    mem_we_s = (resp_r == RESP_OKAY);
                    beat_s   = beat_r + 5'd1;
                    // A misplaced wlast only downgrades an otherwise clean burst.
                    if ((s_axi_wlast != is_last_s) && (resp_r == RESP_OKAY)) begin
                        resp_s = RESP_SLVERR;
                    end else begin
                        resp_s = resp_r;
                    end
                    if (is_last_s) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_RESP: begin
                if (s_axi_bready) begin
                    count_s = burst_count_o + 16'd1;
                    err_s   = err_o | (resp_r != RESP_OKAY);
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // State, burst context and handshake outputs; outputs follow the next state so they are pure flops.
    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= ST_INIT;
            len_r         <= 4'd0;
            idx_r         <= '0;
            beat_r        <= 5'd0;
            resp_r        <= RESP_OKAY;
            burst_count_o <= 16'd0;
            err_o         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            busy_o        <= 1'b0;
        end else begin
            state_r       <= state_s;
            len_r         <= len_s;
            idx_r         <= idx_s;
            beat_r        <= beat_s;
            resp_r        <= resp_s;
            burst_count_o <= count_s;
            err_o         <= err_s;
            s_axi_awready <= (state_s == ST_IDLE);
            s_axi_wready  <= (state_s == ST_DATA);
            s_axi_bvalid  <= (state_s == ST_RESP);
            s_axi_bresp   <= (state_s == ST_RESP) ? resp_s : RESP_OKAY;
            busy_o        <= (state_s == ST_DATA) || (state_s == ST_RESP);
        end
    end

    // Byte-enabled BRAM write port; contents are deliberately not reset.
    always_ff @(posedge aclk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_r[mem_idx_s][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // Side read port, read-before-write on a same-word collision.
    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o <= 64'd0;
        end else begin
            rd_data_o <= mem_r[rd_addr_i];
        end
    end

endmodule

// File: tb/tb_axi_wr_slave_bram.sv
// Directed bench for axi_wr_slave_bram: bursts, strobes, error responses,
// B back-pressure and mid-burst reset, checked against hand-computed values.
module tb_axi_wr_slave_bram;

    localparam logic [31:0] BASE  = 32'h4300_0000;
    localparam int          DEPTH = 1024;

    logic        aclk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] awaddr = 32'd0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  awlen = 4'd0;
    logic [2:0]  awsize = 3'd3;
    logic [1:0]  awburst = 2'b01;
    logic [63:0] wdata = 64'd0;
    logic [7:0]  wstrb = 8'd0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [9:0]  rd_addr = 10'd0;
    logic [63:0] rd_data;
    logic [15:0] burst_count;
    logic        err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    always #5 aclk = ~aclk;

    axi_wr_slave_bram #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .aclk(aclk), .rst_i(rst_i),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .burst_count_o(burst_count), .err_o(err), .busy_o(busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All helpers start and end on a falling edge.
    task automatic aw_send(input logic [31:0] a, input logic [3:0] l,
                           input logic [2:0] sz, input logic [1:0] bu);
        int n = 0;
        awaddr = a; awlen = l; awsize = sz; awburst = bu; awvalid = 1'b1;
        while (!awready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (awready !== 1'b1) begin
            errors++;
            $display("FAIL aw_timeout: awready=%b required 1", awready);
        end
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("FAIL w_timeout: wready=%b required 1", wready);
        end
        @(negedge aclk);
    endtask

    task automatic b_take(output logic [1:0] r);
        int n = 0;
        wvalid = 1'b0;
        bready = 1'b1;
        while (!bvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL b_timeout: bvalid=%b required 1", bvalid);
        end
        r = bresp;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic read_word(input int idx, output logic [63:0] d);
        rd_addr = idx[9:0];
        @(negedge aclk);
        d = rd_data;
    endtask

    task automatic run_burst(input logic [31:0] a, input logic [3:0] l, input logic [2:0] sz,
                             input logic [1:0] bu, input logic [63:0] d0, input logic [7:0] s,
                             output logic [1:0] r);
        aw_send(a, l, sz, bu);
        for (int i = 0; i <= int'(l); i++) begin
            w_send(d0 + 64'(i), s, (i == int'(l)));
        end
        b_take(r);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if ({awready, wready, bvalid, busy, err} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: aw/w/b/busy/err=%b required 00000", {awready, wready, bvalid, busy, err});
        end
        checks++;
        if (bresp !== 2'b00 || burst_count !== 16'd0 || rd_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_values: bresp=%b count=%0d rd=%h required 00 0 0", bresp, burst_count, rd_data);
        end
        rst_i = 1'b0;
        @(negedge aclk);
        checks++;
        if (awready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: awready=%b busy=%b required 1 0", awready, busy);
        end
    endtask

    task automatic test_full_burst();
        logic [1:0]  r;
        logic [63:0] d;
        aw_send(BASE, 4'd15, 3'd3, 2'b01);
        checks++;
        if (wready !== 1'b1 || busy !== 1'b1 || awready !== 1'b0) begin
            errors++;
            $display("FAIL aw_to_w: wready=%b busy=%b awready=%b required 1 1 0", wready, busy, awready);
        end
        for (int i = 0; i < 16; i++) w_send(64'(i), 8'hFF, (i == 15));
        b_take(r);
        exp_count++;
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL full_bresp: got %b required 00", r); end
        checks++;
        if (burst_count !== 16'(exp_count)) begin
            errors++; $display("FAIL full_count: got %0d required %0d", burst_count, exp_count);
        end
        for (int i = 0; i < 16; i++) begin
            read_word(i, d);
            checks++;
            if (d !== 64'(i)) begin errors++; $display("FAIL full_mem[%0d]: got %h required %h", i, d, 64'(i)); end
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  r;
        logic [63:0] d;
        run_burst(BASE + 32'h8, 4'd0, 3'd3, 2'b01, 64'd0, 8'hFF, r);
        run_burst(BASE + 32'h8, 4'd0, 3'd3, 2'b01, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, r);
        exp_count += 2;
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL strb_bresp: got %b required 00", r); end
        read_word(1, d);
        checks++;
        if (d !== 64'h0000_0000_BBBB_BBBB) begin
            errors++; $display("FAIL strb_low: got %h required 00000000bbbbbbbb", d);
        end
        run_burst(BASE + 32'h8, 4'd0, 3'd3, 2'b01, 64'h1122_3344_5566_7788, 8'hA0, r);
        exp_count++;
        read_word(1, d);
        checks++;
        if (d !== 64'h1100_3300_BBBB_BBBB) begin
            errors++; $display("FAIL strb_sparse: got %h required 11003300bbbbbbbb", d);
        end
    endtask

    task automatic test_decerr();
        logic [1:0]  r;
        logic [63:0] d;
        run_burst(BASE + 32'h1FC0, 4'd7, 3'd3, 2'b01, 64'h100, 8'hFF, r);
        exp_count++;
        checks++;
        if (r !== 2'b00 || err !== 1'b0) begin
            errors++; $display("FAIL top_fit: bresp=%b err=%b required 00 0", r, err);
        end
        run_burst(BASE + 32'h1FC0, 4'd15, 3'd3, 2'b01, 64'hDEAD_0000, 8'hFF, r);
        exp_count++;
        checks++;
        if (r !== 2'b11) begin errors++; $display("FAIL dec_overrun: got %b required 11", r); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL dec_err_o: got %b required 1", err); end
        for (int i = 0; i < 8; i++) begin
            read_word(1016 + i, d);
            checks++;
            if (d !== 64'h100 + 64'(i)) begin
                errors++; $display("FAIL dec_mem[%0d]: got %h required %h", 1016 + i, d, 64'h100 + 64'(i));
            end
        end
        run_burst(BASE - 32'h8, 4'd0, 3'd3, 2'b01, 64'hBAD, 8'hFF, r);
        exp_count++;
        checks++;
        if (r !== 2'b11) begin errors++; $display("FAIL dec_below: got %b required 11", r); end
        read_word(0, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL dec_mem0: got %h required 0", d); end
    endtask

    task automatic test_slverr();
        logic [1:0]  r;
        logic [63:0] d;
        run_burst(BASE + 32'h40, 4'd3, 3'd2, 2'b01, 64'hFFFF_0000, 8'hFF, r);
        exp_count++;
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL slv_size: got %b required 10", r); end
        for (int i = 0; i < 4; i++) begin
            read_word(8 + i, d);
            checks++;
            if (d !== 64'(8 + i)) begin errors++; $display("FAIL slv_mem[%0d]: got %h required %h", 8 + i, d, 64'(8 + i)); end
        end
        run_burst(BASE + 32'h44, 4'd0, 3'd3, 2'b01, 64'hEEEE, 8'hFF, r);
        exp_count++;
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL slv_unaligned: got %b required 10", r); end
        run_burst(BASE + 32'h40, 4'd0, 3'd3, 2'b10, 64'hEEEE, 8'hFF, r);
        exp_count++;
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL slv_wrap: got %b required 10", r); end
        read_word(8, d);
        checks++;
        if (d !== 64'd8) begin errors++; $display("FAIL slv_mem8: got %h required 8", d); end
        aw_send(BASE + 32'h80, 4'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) w_send(64'h77 + 64'(i), 8'hFF, (i == 1));
        b_take(r);
        exp_count++;
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL slv_wlast: got %b required 10", r); end
        checks++;
        if (awready !== 1'b1 || burst_count !== 16'(exp_count)) begin
            errors++; $display("FAIL slv_after: awready=%b count=%0d required 1 %0d", awready, burst_count, exp_count);
        end
    endtask

    task automatic test_bready_stall();
        logic [1:0]  r;
        logic [63:0] d;
        aw_send(BASE + 32'hA0, 4'd0, 3'd3, 2'b01);
        w_send(64'h2020, 8'hFF, 1'b1);
        wdata = 64'hBADB_AD00;
        awvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
                errors++; $display("FAIL stall_cycle%0d: bvalid/bresp/awready/wready=%b required 10000", k, {bvalid, bresp, awready, wready});
            end
            @(negedge aclk);
        end
        awvalid = 1'b0;
        b_take(r);
        exp_count++;
        checks++;
        if (r !== 2'b00 || burst_count !== 16'(exp_count)) begin
            errors++; $display("FAIL stall_done: bresp=%b count=%0d required 00 %0d", r, burst_count, exp_count);
        end
        read_word(20, d);
        checks++;
        if (d !== 64'h2020) begin errors++; $display("FAIL stall_mem: got %h required 2020", d); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        aw_send(BASE + 32'h100, 4'd15, 3'd3, 2'b01);
        for (int i = 0; i < 8; i++) w_send(64'h5000 + 64'(i), 8'hFF, 1'b0);
        rst_i = 1'b1;
        wvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if ({busy, wready, bvalid, err} !== 4'b0000 || burst_count !== 16'd0) begin
            errors++; $display("FAIL midrst_state: busy/wready/bvalid/err=%b count=%0d required 0000 0", {busy, wready, bvalid, err}, burst_count);
        end
        rst_i = 1'b0;
        @(negedge aclk);
        exp_count = 0;
        checks++;
        if (awready !== 1'b1 || burst_count !== 16'(exp_count)) begin
            errors++; $display("FAIL midrst_release: awready=%b count=%0d required 1 0", awready, burst_count);
        end
        for (int i = 0; i < 8; i++) begin
            read_word(32 + i, d);
            checks++;
            if (d !== 64'h5000 + 64'(i)) begin
                errors++; $display("FAIL midrst_mem[%0d]: got %h required %h", 32 + i, d, 64'h5000 + 64'(i));
            end
        end
    endtask

    initial begin
        @(negedge aclk);
        test_reset();
        test_full_burst();
        test_strobe();
        test_decerr();
        test_slverr();
        test_bready_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
